// File: rtl/qupls_reglist_seq_if.sv
// Control/data bundle between the instruction extractor and the register-list sequencer.
interface qupls_reglist_seq_if #(
    parameter int NREG = 64,
    parameter int REGW = 7
);
    logic            en_i;
    logic            abort_i;
    logic            start_i;
    logic [NREG-1:0] mask_i;
    logic [REGW-1:0] base_i;
    logic            rev_i;
    logic            busy_o;
    logic            reglist_active_o;
    logic [REGW-1:0] iRn0_o;
    logic [REGW-1:0] iRn1_o;
    logic [REGW-1:0] iRn2_o;
    logic [REGW-1:0] iRn3_o;
    logic [3:0]      v_o;
    logic [REGW-1:0] regcnt_o;
    logic            done_o;

    modport master (
        output en_i, abort_i, start_i, mask_i, base_i, rev_i,
        input  busy_o, reglist_active_o, iRn0_o, iRn1_o, iRn2_o, iRn3_o, v_o, regcnt_o, done_o
    );

    modport slave (
        input  en_i, abort_i, start_i, mask_i, base_i, rev_i,
        output busy_o, reglist_active_o, iRn0_o, iRn1_o, iRn2_o, iRn3_o, v_o, regcnt_o, done_o
    );
endinterface

// File: rtl/qupls_reglist_seq.sv
// Register-list sequencer: expands a latched register mask into groups of up to four register numbers.
// Define QUPLS_REGLIST_REVERSE_EN to allow rev_i to select highest-index-first order.
module qupls_reglist_seq #(
    parameter int NREG = 64,
    parameter int REGW = 7
) (
    input logic                clk_i,
    input logic                rst_i,
    qupls_reglist_seq_if.slave bus
);
    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [NREG-1:0] mask_q;
    logic [REGW-1:0] base_q;
    logic [REGW-1:0] cnt_q;
    logic [REGW-1:0] irn_q [4];
    logic [3:0]      v_q;
    logic [REGW-1:0] regcnt_q;
    logic            done_q;

    logic [NREG-1:0] rem;
    logic [3:0]      hit;
    logic [IW-1:0]   idx [4];
    logic [2:0]      pc;
    logic            rev_sel;

`ifdef QUPLS_REGLIST_REVERSE_EN
    logic rev_q;
    assign rev_sel = rev_q;
`else
    logic unused_rev;
    assign unused_rev = bus.rev_i;
    assign rev_sel    = 1'b0;
`endif

    // Each slot scans from the far end so the last hit is the nearest bit in the chosen order.
    always_comb begin
        rem = mask_q;
        hit = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            idx[k] = '0;
            for (int unsigned b = 0; b < NREG; b++) begin
                if (rev_sel) begin
                    if (rem[IW'(b)]) begin
                        hit[k] = 1'b1;
                        idx[k] = IW'(b);
                    end
                end else begin
                    if (rem[IW'(NREG - 1) - IW'(b)]) begin
                        hit[k] = 1'b1;
                        idx[k] = IW'(NREG - 1) - IW'(b);
                    end
                end
            end
            if (hit[k]) rem[idx[k]] = 1'b0;
        end
        pc = 3'(hit[0]) + 3'(hit[1]) + 3'(hit[2]) + 3'(hit[3]);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            mask_q   <= '0;
            base_q   <= '0;
            cnt_q    <= '0;
            v_q      <= '0;
            regcnt_q <= '0;
            done_q   <= 1'b0;
            for (int unsigned k = 0; k < 4; k++) irn_q[k] <= '0;
`ifdef QUPLS_REGLIST_REVERSE_EN
            rev_q    <= 1'b0;
`endif
        end else if (bus.abort_i) begin
            state    <= IDLE;
            mask_q   <= '0;
            cnt_q    <= '0;
            v_q      <= '0;
            regcnt_q <= '0;
            done_q   <= 1'b0;
            for (int unsigned k = 0; k < 4; k++) irn_q[k] <= '0;
        end else if (bus.en_i) begin
            case (state)
                IDLE: begin
                    v_q      <= '0;
                    regcnt_q <= '0;
                    done_q   <= 1'b0;
                    for (int unsigned k = 0; k < 4; k++) irn_q[k] <= '0;
                    if (bus.start_i) begin
                        mask_q <= bus.mask_i;
                        base_q <= bus.base_i;
                        cnt_q  <= '0;
`ifdef QUPLS_REGLIST_REVERSE_EN
                        rev_q  <= bus.rev_i;
`endif
                        if (bus.mask_i != '0) begin
                            state <= RUN;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    for (int unsigned k = 0; k < 4; k++)
                        irn_q[k] <= hit[k] ? REGW'(idx[k]) + base_q : '0;
                    v_q      <= hit;
                    regcnt_q <= cnt_q;
                    cnt_q    <= cnt_q + REGW'(pc);
                    mask_q   <= rem;
                    if (rem == '0) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    v_q      <= '0;
                    regcnt_q <= '0;
                    done_q   <= 1'b0;
                    for (int unsigned k = 0; k < 4; k++) irn_q[k] <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy_o           = (state != IDLE);
    assign bus.reglist_active_o = (state != IDLE);
    assign bus.iRn0_o           = irn_q[0];
    assign bus.iRn1_o           = irn_q[1];
    assign bus.iRn2_o           = irn_q[2];
    assign bus.iRn3_o           = irn_q[3];
    assign bus.v_o              = v_q;
    assign bus.regcnt_o         = regcnt_q;
    assign bus.done_o           = done_q;
endmodule
